multicycle_control_unit: RTL and testbench

Multicycle successor to the single-cycle decoder: a state machine that sequences each MIPS instruction through FETCH/DECODE/EXEC/MEM/WB, waits on instruction and data memory hit handshakes, and issues per-state datapath enables. It sits between the memory arbiter (ihit/dhit) and the multicycle datapath (PC, IR, MDR, register file, ALU). A parametrised memory-wait watchdog and stall/retire instrumentation are added.

---
 rtl/multicycle_control_unit.sv | 388 ++++++++++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS control unit.
// Each instruction moves through FETCH/DECODE/EXEC/MEM/WB. The FSM waits in
// FETCH for ihit and in MEM for dhit, and drives the per-state datapath
// enables. A miss watchdog and a saturating stall counter are included.

package cpu_types_pkg;

    // ALU operations understood by the datapath ALU.
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    // Primary opcodes (instr[31:26]).
    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_ADDIU = 6'h09,
        OP_SLTI  = 6'h0A,
        OP_SLTIU = 6'h0B,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_XORI  = 6'h0E,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_LBU   = 6'h24,
        OP_LHU   = 6'h25,
        OP_SB    = 6'h28,
        OP_SH    = 6'h29,
        OP_SW    = 6'h2B,
        OP_HALT  = 6'h3F
    } opcode_t;

    // R-type function codes (instr[5:0]).
    typedef enum logic [5:0] {
        F_SLL  = 6'h00,
        F_SRL  = 6'h02,
        F_JR   = 6'h08,
        F_ADD  = 6'h20,
        F_ADDU = 6'h21,
        F_SUB  = 6'h22,
        F_SUBU = 6'h23,
        F_AND  = 6'h24,
        F_OR   = 6'h25,
        F_XOR  = 6'h26,
        F_NOR  = 6'h27,
        F_SLT  = 6'h2A,
        F_SLTU = 6'h2B
    } funct_t;

endpackage

module multicycle_control_unit
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT = 0,
    parameter int STALL_W = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [31:0]        instr,
    input  logic               ihit,
    input  logic               dhit,
    input  logic               Equal,
    output logic               iREN,
    output logic               dREN,
    output logic               dWEN,
    output logic               IRWr,
    output logic               PCWr,
    output logic               MDRWr,
    output logic               RegWr,
    output logic [1:0]         PCSrc,
    output logic [1:0]         RegDst,
    output logic               ExtOp,
    output logic               ALUSrc,
    output logic               MemtoReg,
    output logic               JumpReg,
    output logic               LUI,
    output aluop_t             ALUCtr,
    output logic [1:0]         LDsel,
    output logic [1:0]         SVsel,
    output logic               retire,
    output logic               halt,
    output logic               err,
    output logic [STALL_W-1:0] stall_cnt
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED, S_FAULT
    } state_t;

    // Coarse instruction class that steers the sequencing.
    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_LOAD, C_STORE, C_BRANCH, C_JR, C_J, C_JAL, C_HALT
    } iclass_t;

    typedef struct packed {
        iclass_t    cls;
        logic       bne;
        logic       ext_op;
        logic       alu_src;
        logic       mem_to_reg;
        logic       lui;
        logic [1:0] reg_dst;
        logic [1:0] ld_sel;
        logic [1:0] sv_sel;
        aluop_t     alu_ctr;
    } decode_t;

    // Miss counter only needs to reach TIMEOUT-1; the next miss faults.
    localparam int MISS_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [MISS_W-1:0] MISS_LAST =
        (TIMEOUT > 0) ? MISS_W'(TIMEOUT - 1) : '0;

    state_t             state, next_state;
    logic [31:0]        ir;
    decode_t            dec;
    logic [MISS_W-1:0]  miss_cnt;
    logic [STALL_W-1:0] stall_q;
    logic               miss;
    logic               wd_expire;

    // Register-number and immediate fields of IR belong to the datapath.
    logic unused_ir_fields;
    assign unused_ir_fields = ^ir[25:6];

    // A waiting cycle: the memory this state is blocked on did not hit.
    assign miss = ((state == S_FETCH) && !ihit) || ((state == S_MEM) && !dhit);
    assign wd_expire = (TIMEOUT > 0) && miss && (miss_cnt == MISS_LAST);
    assign stall_cnt = stall_q;

    // Field decode of the latched instruction, same table as the single-cycle decoder.
    always_comb begin
        dec.cls        = C_ALU;
        dec.bne        = 1'b0;
        dec.ext_op     = 1'b0;
        dec.alu_src    = 1'b0;
        dec.mem_to_reg = 1'b0;
        dec.lui        = 1'b0;
        dec.reg_dst    = 2'd0;
        dec.ld_sel     = 2'd0;
        dec.sv_sel     = 2'd0;
        dec.alu_ctr    = ALU_ADD;
        case (ir[31:26])
            OP_RTYPE: begin
                dec.reg_dst = 2'd1;
                case (ir[5:0])
                    F_SLL:          dec.alu_ctr = ALU_SLL;
                    F_SRL:          dec.alu_ctr = ALU_SRL;
                    F_ADD, F_ADDU:  dec.alu_ctr = ALU_ADD;
                    F_SUB, F_SUBU:  dec.alu_ctr = ALU_SUB;
                    F_AND:          dec.alu_ctr = ALU_AND;
                    F_OR:           dec.alu_ctr = ALU_OR;
                    F_XOR:          dec.alu_ctr = ALU_XOR;
                    F_NOR:          dec.alu_ctr = ALU_NOR;
                    F_SLT:          dec.alu_ctr = ALU_SLT;
                    F_SLTU:         dec.alu_ctr = ALU_SLTU;
                    F_JR:           dec.cls     = C_JR;
                    default:        dec.cls     = C_NOP;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                dec.ext_op  = 1'b1;
                dec.alu_src = 1'b1;
            end
            OP_SLTI: begin
                dec.ext_op  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_ctr = ALU_SLT;
            end
            OP_SLTIU: begin
                dec.ext_op  = 1'b1;
                dec.alu_src = 1'b1;
                dec.alu_ctr = ALU_SLTU;
            end
            OP_ANDI: begin
                dec.alu_src = 1'b1;
                dec.alu_ctr = ALU_AND;
            end
            OP_ORI: begin
                dec.alu_src = 1'b1;
                dec.alu_ctr = ALU_OR;
            end
            OP_XORI: begin
                dec.alu_src = 1'b1;
                dec.alu_ctr = ALU_XOR;
            end
            OP_LUI: begin
                dec.alu_src = 1'b1;
                dec.lui     = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.cls     = C_BRANCH;
                dec.bne     = (ir[31:26] == OP_BNE);
                dec.ext_op  = 1'b1;
                dec.alu_ctr = ALU_SUB;
            end
            OP_J: dec.cls = C_J;
            OP_JAL: begin
                dec.cls     = C_JAL;
                dec.reg_dst = 2'd2;
            end
            OP_LW, OP_LBU, OP_LHU: begin
                dec.cls        = C_LOAD;
                dec.ext_op     = 1'b1;
                dec.alu_src    = 1'b1;
                dec.mem_to_reg = 1'b1;
                dec.ld_sel     = (ir[31:26] == OP_LBU) ? 2'd1 :
                                 (ir[31:26] == OP_LHU) ? 2'd2 : 2'd0;
            end
            OP_SB, OP_SH, OP_SW: begin
                dec.cls     = C_STORE;
                dec.ext_op  = 1'b1;
                dec.alu_src = 1'b1;
                dec.sv_sel  = (ir[31:26] == OP_SB) ? 2'd1 :
                              (ir[31:26] == OP_SH) ? 2'd2 : 2'd0;
            end
            OP_HALT: dec.cls = C_HALT;
            default: dec.cls = C_NOP;
        endcase
    end

    // Next-state selection and per-state datapath controls.
    always_comb begin
        // NOTE: every output and next_state is defaulted first so no path through the case infers a latch.
        next_state = state;
        iREN     = 1'b0;
        dREN     = 1'b0;
        dWEN     = 1'b0;
        IRWr     = 1'b0;
        PCWr     = 1'b0;
        MDRWr    = 1'b0;
        RegWr    = 1'b0;
        PCSrc    = 2'd0;
        RegDst   = 2'd0;
        ExtOp    = 1'b0;
        ALUSrc   = 1'b0;
        MemtoReg = 1'b0;
        JumpReg  = 1'b0;
        LUI      = 1'b0;
        ALUCtr   = ALU_SLL;
        LDsel    = 2'd0;
        SVsel    = 2'd0;
        retire   = 1'b0;
        halt     = 1'b0;
        err      = 1'b0;

        // IR is stable from DECODE to WB, so its decode is presented throughout.
        if (state inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
            ExtOp    = dec.ext_op;
            ALUSrc   = dec.alu_src;
            MemtoReg = dec.mem_to_reg;
            LUI      = dec.lui;
            RegDst   = dec.reg_dst;
            ALUCtr   = dec.alu_ctr;
            LDsel    = dec.ld_sel;
            SVsel    = dec.sv_sel;
        end

        unique case (state)
            S_FETCH: begin
                iREN = 1'b1;
                // Reset forces FETCH asynchronously; gating keeps IR/PC writes quiet while it is held.
                if (ihit && !RST) begin
                    IRWr       = 1'b1;
                    PCWr       = 1'b1;
                    next_state = S_DECODE;
                end else if (wd_expire) begin
                    next_state = S_FAULT;
                end
            end
            S_DECODE: begin
                unique case (dec.cls)
                    C_HALT: next_state = S_HALTED;
                    C_J: begin
                        PCWr       = 1'b1;
                        PCSrc      = 2'd2;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_JAL: begin
                        PCWr       = 1'b1;
                        PCSrc      = 2'd2;
                        RegWr      = 1'b1;
                        JumpReg    = 1'b1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_NOP: begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    default: next_state = S_EXEC;
                endcase
            end
            S_EXEC: begin
                unique case (dec.cls)
                    C_BRANCH: begin
                        PCWr       = dec.bne ? !Equal : Equal;
                        PCSrc      = 2'd1;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_JR: begin
                        PCWr       = 1'b1;
                        PCSrc      = 2'd3;
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                    C_LOAD, C_STORE: next_state = S_MEM;
                    C_ALU:           next_state = S_WB;
                    default:         next_state = S_FETCH;
                endcase
            end
            S_MEM: begin
                dREN = (dec.cls == C_LOAD);
                dWEN = (dec.cls == C_STORE);
                if (dhit) begin
                    if (dec.cls == C_LOAD) begin
                        MDRWr      = 1'b1;
                        next_state = S_WB;
                    end else begin
                        retire     = 1'b1;
                        next_state = S_FETCH;
                    end
                end else if (wd_expire) begin
                    next_state = S_FAULT;
                end
            end
            S_WB: begin
                RegWr      = 1'b1;
                retire     = 1'b1;
                next_state = S_FETCH;
            end
            S_HALTED: halt = 1'b1;
            S_FAULT: begin
                halt = 1'b1;
                err  = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // State register and instruction register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= S_FETCH;
            // NOTE: IR is reset so the decode it feeds is defined from the first cycle.
            ir    <= '0;
        end else begin
            // NOTE: non-blocking updates so every register here samples pre-edge values.
            state <= next_state;
            if ((state == S_FETCH) && ihit) begin
                ir <= instr;
            end
        end
    end

    // Consecutive-miss watchdog counter and saturating stall counter.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            miss_cnt <= '0;
            stall_q  <= '0;
        end else begin
            if ((TIMEOUT > 0) && miss && !wd_expire) begin
                miss_cnt <= miss_cnt + 1'b1;
            end else begin
                miss_cnt <= '0;
            end
            if (miss && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Table-driven bench for multicycle_control_unit (TIMEOUT=4).
// Each row is one clock: inputs are driven on the falling edge, the expected
// outputs go into a scoreboard queue, and the DUT outputs are compared 2 ns later.

module tb_multicycle_control_unit;
    import cpu_types_pkg::*;

    localparam int STALL_W = 16;

    logic               CLK   = 1'b0;
    logic               RST   = 1'b0;
    logic [31:0]        instr = '0;
    logic               ihit  = 1'b0;
    logic               dhit  = 1'b0;
    logic               Equal = 1'b0;
    logic               iREN, dREN, dWEN, IRWr, PCWr, MDRWr, RegWr;
    logic [1:0]         PCSrc, RegDst, LDsel, SVsel;
    logic               ExtOp, ALUSrc, MemtoReg, JumpReg, LUI;
    aluop_t             ALUCtr;
    logic               retire, halt, err;
    logic [STALL_W-1:0] stall_cnt;

    multicycle_control_unit #(.TIMEOUT(4), .STALL_W(STALL_W)) dut (
        .CLK(CLK), .RST(RST), .instr(instr), .ihit(ihit), .dhit(dhit),
        .Equal(Equal), .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .IRWr(IRWr),
        .PCWr(PCWr), .MDRWr(MDRWr), .RegWr(RegWr), .PCSrc(PCSrc),
        .RegDst(RegDst), .ExtOp(ExtOp), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
        .JumpReg(JumpReg), .LUI(LUI), .ALUCtr(ALUCtr), .LDsel(LDsel),
        .SVsel(SVsel), .retire(retire), .halt(halt), .err(err),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    // Observed output bundle.
    typedef struct packed {
        logic [6:0] en;     // iREN dREN dWEN IRWr PCWr MDRWr RegWr
        logic [1:0] pcsrc;
        logic [1:0] regdst;
        logic [4:0] dec;    // ExtOp ALUSrc MemtoReg JumpReg LUI
        aluop_t     alu;
        logic [1:0] ld;
        logic [1:0] sv;
        logic [2:0] flags;  // retire halt err
    } obs_t;

    typedef struct {
        logic [31:0] instr;
        logic        rst;
        logic        ihit;
        logic        dhit;
        logic        eq;
        obs_t        exp;
        int          st;    // expected stall_cnt, -1 = not checked
    } vec_t;

    vec_t vecs[$];
    obs_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [31:0] I_ADDI = 32'h2001_0005;
    localparam logic [31:0] I_LW   = 32'h8C22_0004;
    localparam logic [31:0] I_BEQ  = 32'h1022_0003;
    localparam logic [31:0] I_BNE  = 32'h1422_0003;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JR   = 32'h03E0_0008;
    localparam logic [31:0] I_NOP  = 32'h0400_0000;
    localparam logic [31:0] I_LHU  = 32'h9422_0002;
    localparam logic [31:0] I_SB   = 32'hA022_0000;
    localparam logic [31:0] I_SW   = 32'hAC22_0000;
    localparam logic [31:0] I_HALT = 32'hFFFF_FFFF;

    function automatic obs_t o(input logic [6:0] en, input logic [1:0] pcs,
                               input logic [1:0] rd, input logic [4:0] dc,
                               input aluop_t alu, input logic [2:0] fl,
                               input logic [1:0] ld = 2'd0,
                               input logic [1:0] sv = 2'd0);
        obs_t r;
        r.en = en; r.pcsrc = pcs; r.regdst = rd; r.dec = dc;
        r.alu = alu; r.ld = ld; r.sv = sv; r.flags = fl;
        return r;
    endfunction

    function automatic obs_t observe();
        obs_t r;
        r.en     = {iREN, dREN, dWEN, IRWr, PCWr, MDRWr, RegWr};
        r.pcsrc  = PCSrc;
        r.regdst = RegDst;
        r.dec    = {ExtOp, ALUSrc, MemtoReg, JumpReg, LUI};
        r.alu    = ALUCtr;
        r.ld     = LDsel;
        r.sv     = SVsel;
        r.flags  = {retire, halt, err};
        return r;
    endfunction

    task automatic add(input logic [31:0] i, input logic r, input logic ih,
                       input logic dh, input logic eq, input obs_t e,
                       input int st = -1);
        vec_t v;
        v.instr = i; v.rst = r; v.ihit = ih; v.dhit = dh; v.eq = eq;
        v.exp = e; v.st = st;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    initial begin
        obs_t rs, fh, d_addi, d_lw, d_br, d_sw, d_lhu, d_sb, hlt, flt;
        rs     = o(7'b1000000, 2'd0, 2'd0, 5'b00000, ALU_SLL, 3'b000);
        fh     = o(7'b1001100, 2'd0, 2'd0, 5'b00000, ALU_SLL, 3'b000);
        d_addi = o(7'b0000000, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b000);
        d_lw   = o(7'b0000000, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b000);
        d_br   = o(7'b0000000, 2'd0, 2'd0, 5'b10000, ALU_SUB, 3'b000);
        d_sw   = o(7'b0000000, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b000);
        d_lhu  = o(7'b0000000, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b000, 2'd2);
        d_sb   = o(7'b0000000, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b000, 2'd0, 2'd1);
        hlt    = o(7'b0000000, 2'd0, 2'd0, 5'b00000, ALU_SLL, 3'b010);
        flt    = o(7'b0000000, 2'd0, 2'd0, 5'b00000, ALU_SLL, 3'b011);

        // Reset with ihit high: only iREN, no IR/PC write.
        add(32'h0, 1, 1, 0, 0, rs, 0);
        // ADDI: two fetch misses, then DECODE/EXEC/WB; stray hits ignored.
        add(I_ADDI, 0, 0, 0, 0, rs);
        add(I_ADDI, 0, 0, 0, 0, rs);
        add(I_ADDI, 0, 1, 0, 0, fh);
        add(I_ADDI, 0, 1, 1, 0, d_addi);
        add(I_ADDI, 0, 1, 1, 0, d_addi);
        add(I_ADDI, 0, 1, 1, 0, o(7'b0000001, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b100));
        // LW: immediate ihit, three data misses, MDRWr on the hit, WB.
        add(I_LW, 0, 1, 0, 0, fh, 2);
        add(I_LW, 0, 0, 1, 0, d_lw);
        add(I_LW, 0, 0, 0, 0, d_lw);
        for (int k = 0; k < 3; k++)
            add(I_LW, 0, 0, 0, 0, o(7'b0100000, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b000));
        add(I_LW, 0, 0, 1, 0, o(7'b0100010, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b000));
        add(I_LW, 0, 0, 0, 0, o(7'b0000001, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b100));
        // BEQ taken / not taken, BNE not equal / equal.
        add(I_BEQ, 0, 1, 0, 1, fh, 5);
        add(I_BEQ, 0, 0, 0, 1, d_br);
        add(I_BEQ, 0, 0, 0, 1, o(7'b0000100, 2'd1, 2'd0, 5'b10000, ALU_SUB, 3'b100));
        add(I_BEQ, 0, 1, 0, 0, fh);
        add(I_BEQ, 0, 0, 0, 1, d_br);
        add(I_BEQ, 0, 0, 0, 0, o(7'b0000000, 2'd1, 2'd0, 5'b10000, ALU_SUB, 3'b100));
        add(I_BNE, 0, 1, 0, 0, fh);
        add(I_BNE, 0, 0, 0, 1, d_br);
        add(I_BNE, 0, 0, 0, 0, o(7'b0000100, 2'd1, 2'd0, 5'b10000, ALU_SUB, 3'b100));
        add(I_BNE, 0, 1, 0, 0, fh);
        add(I_BNE, 0, 0, 0, 0, d_br);
        add(I_BNE, 0, 0, 0, 1, o(7'b0000000, 2'd1, 2'd0, 5'b10000, ALU_SUB, 3'b100));
        // JAL and J complete in DECODE.
        add(I_JAL, 0, 1, 0, 0, fh);
        add(I_JAL, 0, 0, 0, 0, o(7'b0000101, 2'd2, 2'd2, 5'b00010, ALU_ADD, 3'b100));
        add(I_J, 0, 1, 0, 0, fh);
        add(I_J, 0, 0, 0, 0, o(7'b0000100, 2'd2, 2'd0, 5'b00000, ALU_ADD, 3'b100));
        // JR completes in EXEC with PCSrc=3.
        add(I_JR, 0, 1, 0, 0, fh);
        add(I_JR, 0, 0, 0, 0, o(7'b0000000, 2'd0, 2'd1, 5'b00000, ALU_ADD, 3'b000));
        add(I_JR, 0, 0, 0, 0, o(7'b0000100, 2'd3, 2'd1, 5'b00000, ALU_ADD, 3'b100));
        // Unknown opcode retires as a NOP in DECODE.
        add(I_NOP, 0, 1, 0, 0, fh);
        add(I_NOP, 0, 0, 0, 0, o(7'b0000000, 2'd0, 2'd0, 5'b00000, ALU_ADD, 3'b100));
        // LHU: halfword load select.
        add(I_LHU, 0, 1, 0, 0, fh);
        add(I_LHU, 0, 0, 0, 0, d_lhu);
        add(I_LHU, 0, 0, 0, 0, d_lhu);
        add(I_LHU, 0, 0, 1, 0, o(7'b0100010, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b000, 2'd2));
        add(I_LHU, 0, 0, 0, 0, o(7'b0000001, 2'd0, 2'd0, 5'b11100, ALU_ADD, 3'b100, 2'd2));
        // SB: byte store retires on the dhit in MEM.
        add(I_SB, 0, 1, 0, 0, fh);
        add(I_SB, 0, 0, 0, 0, d_sb);
        add(I_SB, 0, 0, 0, 0, d_sb);
        add(I_SB, 0, 0, 1, 0, o(7'b0010000, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b100, 2'd0, 2'd1));
        // SW interrupted by reset in MEM: dWEN drops at once.
        add(I_SW, 0, 1, 0, 0, fh);
        add(I_SW, 0, 0, 0, 0, d_sw);
        add(I_SW, 0, 0, 0, 0, d_sw);
        add(I_SW, 0, 0, 0, 0, o(7'b0010000, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b000));
        add(I_SW, 1, 1, 0, 0, rs, 0);
        // Watchdog: three misses then a hit in the 4th cycle -> no fault.
        add(I_ADDI, 0, 0, 0, 0, rs, 0);
        add(I_ADDI, 0, 0, 0, 0, rs);
        add(I_ADDI, 0, 0, 0, 0, rs);
        add(I_ADDI, 0, 1, 0, 0, fh);
        add(I_ADDI, 0, 0, 0, 0, d_addi, 3);
        add(I_ADDI, 0, 0, 0, 0, d_addi);
        add(I_ADDI, 0, 0, 0, 0, o(7'b0000001, 2'd0, 2'd0, 5'b11000, ALU_ADD, 3'b100));
        // Watchdog: four consecutive misses -> FAULT, sticky despite ihit.
        for (int k = 0; k < 4; k++) add(I_ADDI, 0, 0, 0, 0, rs);
        add(I_ADDI, 0, 1, 1, 0, flt, 7);
        add(I_ADDI, 0, 1, 1, 0, flt, 7);
        // Reset leaves FAULT; then HALT is held for ten cycles.
        add(I_HALT, 1, 1, 0, 0, rs, 0);
        add(I_HALT, 0, 1, 0, 0, fh);
        add(I_HALT, 0, 1, 0, 0, o(7'b0000000, 2'd0, 2'd0, 5'b00000, ALU_ADD, 3'b000));
        for (int k = 0; k < 10; k++) add(I_HALT, 0, 1, 1, 0, hlt);

        for (int k = 0; k < vecs.size(); k++) begin
            obs_t got, want;
            @(negedge CLK);
            RST   = vecs[k].rst;
            instr = vecs[k].instr;
            ihit  = vecs[k].ihit;
            dhit  = vecs[k].dhit;
            Equal = vecs[k].eq;
            sb.push_back(vecs[k].exp);
            #2;
            got  = observe();
            want = sb.pop_front();
            check($sformatf("vec%0d", k), 32'(got), 32'(want));
            if (vecs[k].st >= 0)
                check($sformatf("stall%0d", k), 32'(stall_cnt), 32'(vecs[k].st));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
